// File: rtl/dbi_pkg.sv
// rtl/dbi_pkg.sv - shared state encoding and constants for the DBI access arbiter
package dbi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_UNLK_RD = 3'd1,
    ST_UNLK_WR = 3'd2,
    ST_ACCESS  = 3'd3,
    ST_DONE    = 3'd4
  } dbi_state_e;

  localparam logic [31:0] DEF_ADDR_WR_PROT = 32'h0000_08BC;
  localparam int          DEF_WR_PROT_BIT  = 0;
  localparam logic [31:0] TIMEOUT_RDATA    = 32'hFFFF_FFFF;
  localparam int          TMO_W            = 8;

  function automatic logic [31:0] unlock_value(input logic [31:0] cur, input int bit_pos);
    return cur | (32'd1 << bit_pos);
  endfunction

endpackage

// File: rtl/dbi_rr_arbiter.sv
// rtl/dbi_rr_arbiter.sv - combinational round-robin pick starting after the last winner
module dbi_rr_arbiter
  import dbi_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  logic [IDX_W-1:0] cand;

  // Walk from farthest to nearest so the nearest set bit after ptr_i wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
      if (req_i[cand]) begin
        grant_o       = '0;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
        valid_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dbi_access_arbiter.sv
// rtl/dbi_access_arbiter.sv - round-robin DBI master with ack timeout and one-time write-protect unlock
module dbi_access_arbiter
  import dbi_pkg::*;
#(
  parameter int          NUM_REQ        = 2,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          AUTO_UNLOCK    = 1,
  parameter logic [31:0] ADDR_WR_PROT   = DEF_ADDR_WR_PROT,
  parameter int          WR_PROT_BIT    = DEF_WR_PROT_BIT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_wr,
  input  logic [NUM_REQ-1:0]     req_cs2,
  input  logic [NUM_REQ*32-1:0]  req_addr,
  input  logic [NUM_REQ*32-1:0]  req_wdata,
  input  logic [NUM_REQ*4-1:0]   req_be,
  output logic [NUM_REQ-1:0]     done,
  output logic [31:0]            rdata,
  output logic                   err,
  input  logic                   init_active,
  input  logic                   relock,
  output logic                   drp_dbi_cs,
  output logic                   drp_dbi_cs2_exp,
  output logic [3:0]             drp_dbi_wr,
  output logic [31:0]            drp_dbi_addr,
  output logic [31:0]            drp_dbi_din,
  output logic                   drp_app_dbi_ro_wr_disable,
  input  logic [31:0]            drp_lbc_dbi_dout,
  input  logic                   drp_lbc_dbi_ack
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  dbi_state_e         state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic               unlocked_q;
  logic [TMO_W-1:0]   cnt_q;
  logic [NUM_REQ-1:0] lat_gnt_q;
  logic               lat_wr_q;
  logic               lat_cs2_q;
  logic [31:0]        lat_addr_q;
  logic [31:0]        lat_wdata_q;
  logic [3:0]         lat_be_q;
  logic [31:0]        unlk_din_q;
  logic               cs_q;
  logic               cs2_q;
  logic [3:0]         wr_q;
  logic [31:0]        addr_q;
  logic [31:0]        din_q;
  logic [NUM_REQ-1:0] done_q;
  logic [31:0]        rdata_q;
  logic               err_q;
  logic               ro_dis_q;

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_valid;
  logic               sel_wr;
  logic               sel_cs2;
  logic [31:0]        sel_addr;
  logic [31:0]        sel_wdata;
  logic [3:0]         sel_be;

  dbi_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (gnt),
    .idx_o   (gnt_idx),
    .valid_o (gnt_valid)
  );

  always_comb begin
    sel_wr    = 1'b0;
    sel_cs2   = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_wr    = req_wr[i];
        sel_cs2   = req_cs2[i];
        sel_addr  = req_addr[i*32 +: 32];
        sel_wdata = req_wdata[i*32 +: 32];
        sel_be    = req_be[i*4 +: 4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      unlocked_q  <= 1'b0;
      cnt_q       <= '0;
      lat_gnt_q   <= '0;
      lat_wr_q    <= 1'b0;
      lat_cs2_q   <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_be_q    <= '0;
      unlk_din_q  <= '0;
      cs_q        <= 1'b0;
      cs2_q       <= 1'b0;
      wr_q        <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      ro_dis_q    <= 1'b1;
    end else begin
      ro_dis_q <= ~init_active;
      done_q   <= '0;
      if (relock) unlocked_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (gnt_valid) begin
            ptr_q       <= gnt_idx;
            lat_gnt_q   <= gnt;
            lat_wr_q    <= sel_wr;
            lat_cs2_q   <= sel_cs2;
            lat_addr_q  <= sel_addr;
            lat_wdata_q <= sel_wdata;
            lat_be_q    <= sel_be;
            cs_q        <= 1'b1;
            cnt_q       <= '0;
            if (sel_wr && (AUTO_UNLOCK != 0) && !unlocked_q) begin
              state_q <= ST_UNLK_RD;
              addr_q  <= ADDR_WR_PROT;
              din_q   <= '0;
              wr_q    <= '0;
              cs2_q   <= 1'b0;
            end else begin
              state_q <= ST_ACCESS;
              addr_q  <= sel_addr;
              din_q   <= sel_wr ? sel_wdata : '0;
              wr_q    <= sel_wr ? sel_be : 4'h0;
              cs2_q   <= sel_cs2;
            end
          end
        end

        ST_UNLK_RD, ST_UNLK_WR, ST_ACCESS: begin
          // cs low here means the previous sub-access just finished: launch the next one.
          if (!cs_q) begin
            cs_q <= 1'b1;
            if (state_q == ST_UNLK_WR) begin
              addr_q <= ADDR_WR_PROT;
              din_q  <= unlk_din_q;
              wr_q   <= 4'hF;
              cs2_q  <= 1'b0;
            end else begin
              addr_q <= lat_addr_q;
              din_q  <= lat_wr_q ? lat_wdata_q : '0;
              wr_q   <= lat_wr_q ? lat_be_q : 4'h0;
              cs2_q  <= lat_cs2_q;
            end
          end else if (drp_lbc_dbi_ack) begin
            cs_q  <= 1'b0;
            cs2_q <= 1'b0;
            wr_q  <= '0;
            cnt_q <= '0;
            if (state_q == ST_UNLK_RD) begin
              unlk_din_q <= unlock_value(drp_lbc_dbi_dout, WR_PROT_BIT);
              state_q    <= ST_UNLK_WR;
            end else if (state_q == ST_UNLK_WR) begin
              if (!relock) unlocked_q <= 1'b1;
              state_q <= ST_ACCESS;
            end else begin
              state_q <= ST_DONE;
              done_q  <= lat_gnt_q;
              rdata_q <= lat_wr_q ? '0 : drp_lbc_dbi_dout;
              err_q   <= 1'b0;
            end
          end else if (cnt_q == TMO_LAST) begin
            cs_q    <= 1'b0;
            cs2_q   <= 1'b0;
            wr_q    <= '0;
            cnt_q   <= '0;
            state_q <= ST_DONE;
            done_q  <= lat_gnt_q;
            rdata_q <= TIMEOUT_RDATA;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          rdata_q <= '0;
          err_q   <= 1'b0;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign done                      = done_q;
  assign rdata                     = rdata_q;
  assign err                       = err_q;
  assign drp_dbi_cs                = cs_q;
  assign drp_dbi_cs2_exp           = cs2_q;
  assign drp_dbi_wr                = wr_q;
  assign drp_dbi_addr              = addr_q;
  assign drp_dbi_din               = din_q;
  assign drp_app_dbi_ro_wr_disable = ro_dis_q;

endmodule

// File: tb/tb_dbi_access_arbiter.sv
// tb/tb_dbi_access_arbiter.sv - self-checking bench with DBI slave and transaction-level reference model
module tb_dbi_access_arbiter;

  localparam int          NR      = 2;
  localparam int          TO      = 255;
  localparam logic [31:0] ADDR_WP = 32'h0000_08BC;
  localparam int          NEVER   = 100000;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wr;
    logic [31:0] din;
    logic        cs2;
    int          len;
    int          gap;
  } op_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req, req_wr, req_cs2;
  logic [NR*32-1:0]  req_addr, req_wdata;
  logic [NR*4-1:0]   req_be;
  logic [NR-1:0]     done;
  logic [31:0]       rdata;
  logic              err;
  logic              init_active, relock;
  logic              drp_dbi_cs, drp_dbi_cs2_exp;
  logic [3:0]        drp_dbi_wr;
  logic [31:0]       drp_dbi_addr, drp_dbi_din;
  logic              drp_app_dbi_ro_wr_disable;
  logic [31:0]       drp_lbc_dbi_dout;
  logic              drp_lbc_dbi_ack;

  logic [31:0] r_addr [NR];
  logic [31:0] r_wdata[NR];
  logic [3:0]  r_be   [NR];

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [logic [31:0]];
  op_t         log_q[$];
  int          ack_at = NEVER;
  bit          spurious = 1'b0;

  int m_ptr = 0;
  bit m_unlocked = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req_addr[i*32 +: 32]  = r_addr[i];
      req_wdata[i*32 +: 32] = r_wdata[i];
      req_be[i*4 +: 4]      = r_be[i];
    end
  end

  dbi_access_arbiter #(
    .NUM_REQ(NR), .TIMEOUT_CYCLES(TO), .AUTO_UNLOCK(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_wr(req_wr), .req_cs2(req_cs2),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .done(done), .rdata(rdata), .err(err),
    .init_active(init_active), .relock(relock),
    .drp_dbi_cs(drp_dbi_cs), .drp_dbi_cs2_exp(drp_dbi_cs2_exp), .drp_dbi_wr(drp_dbi_wr),
    .drp_dbi_addr(drp_dbi_addr), .drp_dbi_din(drp_dbi_din),
    .drp_app_dbi_ro_wr_disable(drp_app_dbi_ro_wr_disable),
    .drp_lbc_dbi_dout(drp_lbc_dbi_dout), .drp_lbc_dbi_ack(drp_lbc_dbi_ack)
  );

  function automatic logic [31:0] rdval(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], 16'hC0DE};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // DBI slave: acks on cycle ack_at of each cs window and logs every access when cs falls.
  initial begin
    op_t cur;
    int  cyc;
    int  gap;
    bit  in_acc;
    cyc = 0; gap = 0; in_acc = 1'b0;
    cur = '{32'h0, 4'h0, 32'h0, 1'b0, 0, 0};
    drp_lbc_dbi_ack  = 1'b0;
    drp_lbc_dbi_dout = 32'h0;
    forever begin
      @(negedge clk);
      if (drp_dbi_cs === 1'b1) begin
        if (!in_acc) begin
          in_acc = 1'b1;
          cur = '{drp_dbi_addr, drp_dbi_wr, drp_dbi_din, drp_dbi_cs2_exp, 0, gap};
          cyc = 0;
        end
        cyc++;
        if (cyc == ack_at) begin
          drp_lbc_dbi_ack  = 1'b1;
          drp_lbc_dbi_dout = rdval(cur.addr);
          if (cur.wr != 4'h0) begin
            logic [31:0] v;
            v = rdval(cur.addr);
            for (int b = 0; b < 4; b++) if (cur.wr[b]) v[b*8 +: 8] = cur.din[b*8 +: 8];
            mem[cur.addr] = v;
          end
        end else begin
          drp_lbc_dbi_ack  = 1'b0;
          drp_lbc_dbi_dout = $urandom;
        end
      end else begin
        if (in_acc) begin
          cur.len = cyc;
          log_q.push_back(cur);
          in_acc = 1'b0;
          gap = 0;
        end
        gap++;
        drp_lbc_dbi_ack  = spurious;
        drp_lbc_dbi_dout = $urandom;
      end
    end
  end

  function automatic int rr_pick(input logic [NR-1:0] m);
    for (int k = 1; k <= NR; k++) if (m[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    return 0;
  endfunction

  task automatic wait_done(input int budget, output logic [NR-1:0] d, output int n);
    d = '0;
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (done !== '0) begin
        d = done;
        break;
      end
    end
  endtask

  task automatic run_txn(input logic [NR-1:0] mask, input int ackd, input bit hold,
                         input string tag, output int lat);
    int            w, n;
    logic [NR-1:0] d;
    logic [31:0]   e_rdata, v;
    logic          e_err;
    bit            tmo, unl;
    op_t           q[$];
    w   = rr_pick(mask);
    tmo = (ackd >= TO);
    unl = req_wr[w] && !m_unlocked;
    if (unl) begin
      v = rdval(ADDR_WP);
      q.push_back('{ADDR_WP, 4'h0, 32'h0, 1'b0, ackd + 1, 0});
      q.push_back('{ADDR_WP, 4'hF, v | 32'h1, 1'b0, ackd + 1, 0});
    end
    q.push_back('{r_addr[w], req_wr[w] ? r_be[w] : 4'h0, r_wdata[w], req_cs2[w], ackd + 1, 0});
    e_rdata = req_wr[w] ? 32'h0 : rdval(r_addr[w]);
    e_err   = 1'b0;
    if (tmo) begin
      while (q.size() > 1) void'(q.pop_back());
      q[0].len = TO;
      e_rdata  = 32'hFFFF_FFFF;
      e_err    = 1'b1;
    end
    ack_at = tmo ? NEVER : ackd + 1;
    log_q.delete();
    req = mask;
    wait_done(1200, d, n);
    if (!hold) req = '0;
    lat = n + 1;
    chk({tag, ".done"}, 32'(d), 32'(1) << w);
    chk({tag, ".rdata"}, rdata, e_rdata);
    chk({tag, ".err"}, 32'(err), 32'(e_err));
    @(negedge clk);
    chk({tag, ".nops"}, 32'(log_q.size()), 32'(q.size()));
    for (int i = 0; i < q.size() && i < log_q.size(); i++) begin
      chk({tag, ".addr"}, log_q[i].addr, q[i].addr);
      chk({tag, ".wr"}, 32'(log_q[i].wr), 32'(q[i].wr));
      if (q[i].wr != 4'h0) chk({tag, ".din"}, log_q[i].din, q[i].din);
      chk({tag, ".cs2"}, 32'(log_q[i].cs2), 32'(q[i].cs2));
      chk({tag, ".cslen"}, 32'(log_q[i].len), 32'(q[i].len));
      chk({tag, ".gap"}, 32'(log_q[i].gap >= 1), 32'd1);
    end
    m_ptr = w;
    if (unl && !tmo) m_unlocked = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n = 1'b0; req = '0; req_wr = '0; req_cs2 = '0;
    init_active = 1'b0; relock = 1'b0;
    for (int i = 0; i < NR; i++) begin r_addr[i] = '0; r_wdata[i] = '0; r_be[i] = '0; end
    mem[ADDR_WP] = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst.cs", 32'(drp_dbi_cs), 32'd0);
    chk("rst.cs2", 32'(drp_dbi_cs2_exp), 32'd0);
    chk("rst.wr", 32'(drp_dbi_wr), 32'd0);
    chk("rst.addr", drp_dbi_addr, 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    chk("rst.rodis", 32'(drp_app_dbi_ro_wr_disable), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    mem[32'h10] = 32'h1234_5678;
    r_addr[0] = 32'h10; req_wr = 2'b00;
    run_txn(2'b01, 2, 1'b0, "rd_ack2", lat);
    run_txn(2'b01, 0, 1'b0, "rd_min", lat);
    chk("rd_min.latency", 32'(lat), 32'd3);

    r_addr[1] = 32'h4; r_wdata[1] = 32'hA5A5_A5A5; r_be[1] = 4'hF; req_wr = 2'b10;
    run_txn(2'b10, 0, 1'b0, "wr_unlock", lat);
    chk("wr_unlock.mem", rdval(32'h4), 32'hA5A5_A5A5);
    r_addr[1] = 32'h8; r_wdata[1] = $urandom;
    run_txn(2'b10, 1, 1'b0, "wr_nounlock", lat);

    req_wr = 2'b00; r_addr[0] = 32'h20; r_addr[1] = 32'h24;
    for (int k = 0; k < 4; k++) run_txn(2'b11, $urandom_range(0, 3), (k != 3), "rr_hold", lat);

    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < NR; i++) begin
        r_addr[i]  = 32'($urandom_range(0, 63)) << 2;
        r_wdata[i] = $urandom;
        r_be[i]    = 4'($urandom_range(1, 15));
      end
      req_wr  = NR'($urandom);
      req_cs2 = NR'($urandom);
      run_txn(NR'($urandom_range(1, 3)), $urandom_range(0, 4), 1'b0, "rand", lat);
    end
    req_cs2 = '0;

    req_wr = 2'b00; r_addr[0] = 32'h30;
    run_txn(2'b01, NEVER, 1'b0, "tmo_rd", lat);
    run_txn(2'b01, 0, 1'b0, "after_tmo", lat);
    run_txn(2'b01, TO - 1, 1'b0, "ack_last", lat);

    spurious = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("spur.cs", 32'(drp_dbi_cs), 32'd0);
      chk("spur.done", 32'(done), 32'd0);
    end
    spurious = 1'b0;

    init_active = 1'b1;
    @(negedge clk);
    chk("init.rodis0", 32'(drp_app_dbi_ro_wr_disable), 32'd0);
    init_active = 1'b0;
    @(negedge clk);
    chk("init.rodis1", 32'(drp_app_dbi_ro_wr_disable), 32'd1);

    relock = 1'b1;
    @(negedge clk);
    relock = 1'b0;
    m_unlocked = 1'b0;
    mem[ADDR_WP] = 32'h0000_0F00;
    r_addr[0] = 32'h44; r_wdata[0] = 32'hDEAD_BEEF; r_be[0] = 4'h3; req_wr = 2'b01;
    run_txn(2'b01, 1, 1'b0, "relock_wr", lat);

    r_addr[1] = 32'h40; r_wdata[1] = 32'h0BAD_F00D; r_be[1] = 4'hF; req_wr = 2'b10;
    ack_at = NEVER;
    req = 2'b10;
    repeat (3) @(negedge clk);
    chk("rstmid.cs_on", 32'(drp_dbi_cs), 32'd1);
    rst_n = 1'b0;
    req = '0;
    @(negedge clk);
    chk("rstmid.cs_off", 32'(drp_dbi_cs), 32'd0);
    chk("rstmid.done0", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid.done1", 32'(done), 32'd0);
    m_ptr = 0; m_unlocked = 1'b0;
    log_q.delete();

    req_wr = 2'b01;
    run_txn(2'b01, NEVER, 1'b0, "unlk_tmo", lat);
    run_txn(2'b01, 0, 1'b0, "unlk_retry", lat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
